// File: rtl/time_digit_entry.sv
// Keypad digit entry for the hour/minute/second time-setting path.
// Shifts BCD digits into the enabled field, validates on '#', commits on complete.
module time_digit_entry #(
  parameter logic [7:0] HOUR_MAX_BCD   = 8'h23,
  parameter logic [7:0] MINSEC_MAX_BCD = 8'h59,
  parameter logic [3:0] KEY_CLEAR      = 4'hA,
  parameter logic [3:0] KEY_SHARP      = 4'hB
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       hour_en,
  input  logic       min_en,
  input  logic       sec_en,
  input  logic       complete_setting,
  output logic       sharp,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       load_time,
  output logic       entry_error
);

  typedef enum logic [2:0] {
    ENTRY, VALIDATE, ADVANCE, LOAD, HOLD
  } state_t;

  typedef enum logic [1:0] {
    F_NONE, F_HOUR, F_MIN, F_SEC
  } fid_t;

  state_t     state_q, state_d;
  fid_t       fid_q, fid_d;
  fid_t       act;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       sharp_q, sharp_d;
  logic       load_q, load_d;
  logic       err_q, err_d;

  logic [7:0] act_val;
  logic [7:0] chk_val;
  logic [7:0] limit;
  logic       in_range;
  logic       wr_en;
  fid_t       wr_fid;
  logic [7:0] wr_val;

  always_comb begin
    act = F_NONE;
    priority case (1'b1)
      hour_en: act = F_HOUR;
      min_en:  act = F_MIN;
      sec_en:  act = F_SEC;
      default: act = F_NONE;
    endcase
  end

  assign act_val = (act == F_HOUR) ? hour_q :
                   (act == F_MIN)  ? min_q  : sec_q;
  assign chk_val = (fid_q == F_HOUR) ? hour_q :
                   (fid_q == F_MIN)  ? min_q  : sec_q;
  assign limit   = (fid_q == F_HOUR) ? HOUR_MAX_BCD
                                     : MINSEC_MAX_BCD;
  // BCD compare is plain binary compare once both nibbles are decimal
  assign in_range = (chk_val[7:4] <= 4'd9)
                 && (chk_val[3:0] <= 4'd9)
                 && (chk_val <= limit);

  always_comb begin
    state_d = state_q;
    fid_d   = fid_q;
    sharp_d = 1'b0;
    load_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_fid  = act;
    wr_val  = 8'h00;
    unique case (state_q)
      ENTRY: begin
        if (complete_setting) begin
          state_d = LOAD;
          load_d  = 1'b1;
        end else if (key_valid && act != F_NONE) begin
          if (key_code <= 4'd9) begin
            wr_en  = 1'b1;
            wr_val = {act_val[3:0], key_code};
          end else if (key_code == KEY_CLEAR) begin
            wr_en  = 1'b1;
          end else if (key_code == KEY_SHARP) begin
            fid_d   = act;
            state_d = VALIDATE;
          end
        end
      end
      VALIDATE: begin
        if (in_range) begin
          state_d = ADVANCE;
          sharp_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_fid  = fid_q;
          err_d   = 1'b1;
          state_d = ENTRY;
        end
      end
      ADVANCE: state_d = ENTRY;
      LOAD:    state_d = HOLD;
      HOLD:    if (!complete_setting) state_d = ENTRY;
      default: state_d = ENTRY;
    endcase

    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (wr_en) begin
      unique case (wr_fid)
        F_HOUR:  hour_d = wr_val;
        F_MIN:   min_d  = wr_val;
        F_SEC:   sec_d  = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ENTRY;
      fid_q   <= F_NONE;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      sharp_q <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fid_q   <= fid_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      sharp_q <= sharp_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign sharp       = sharp_q;
  assign load_time   = load_q;
  assign entry_error = err_q;
  assign hour_bcd    = hour_q;
  assign min_bcd     = min_q;
  assign sec_bcd     = sec_q;

endmodule

// File: doc/time_digit_entry.md
Name: time_digit_entry

Overview:
- Keypad-side counterpart of the hour/minute/second field sequencer in the nap-alarm time-setting path.
- Accepts decoded keypad strobes and accumulates two BCD digits into whichever field the sequencer currently enables.
- Validates the field when '#' is pressed and only then forwards a one-cycle sharp pulse to the sequencer.
- Commits the full time with a one-cycle load strobe when the sequencer reports setting complete.

Parameters:
HOUR_MAX_BCD, 8'h23, largest legal hour field value (BCD)
MINSEC_MAX_BCD, 8'h59, largest legal minute/second field value (BCD)
KEY_CLEAR, 4'hA, key code that clears the active field ('*')
KEY_SHARP, 4'hB, key code that requests field advance ('#')

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0-9 digit, KEY_CLEAR, KEY_SHARP; other codes ignored
hour_en  input  1  sequencer: hour field active
min_en  input  1  sequencer: minute field active
sec_en  input  1  sequencer: second field active
complete_setting  input  1  sequencer: all fields entered (level)
sharp  output  1  one-cycle advance pulse to sequencer
hour_bcd  output  8  hour entry register (BCD)
min_bcd  output  8  minute entry register (BCD)
sec_bcd  output  8  second entry register (BCD)
load_time  output  1  one-cycle commit strobe; *_bcd stable this cycle
entry_error  output  1  one-cycle pulse: '#' rejected on out-of-range field

Behaviour:
- Reset values: all outputs 0; *_bcd = 8'h00; state ENTRY.
- Active field: hour_en > min_en > sec_en, in that priority when more than one is high. If none is high, digit, clear and '#' keys are ignored.
- States:
  - ENTRY: accept keys.
  - VALIDATE: one cycle, range check.
  - ADVANCE: sharp = 1 for exactly one cycle.
  - LOAD: load_time = 1 for exactly one cycle.
  - HOLD: wait for complete_setting = 0.
- ENTRY, digit key (0-9): active field <= {field[3:0], digit}. Shift-in; a third digit drops the oldest. Register updates on the cycle after the strobe.
- ENTRY, KEY_CLEAR: active field <= 8'h00.
- ENTRY, KEY_SHARP: latch the active-field id, go to VALIDATE.
- VALIDATE:
  - Limit is HOUR_MAX_BCD for the hour field, MINSEC_MAX_BCD otherwise. A field passes if each nibble is ≤ 9 and field ≤ limit.
  - Pass: go to ADVANCE.
  - Fail: clear the field to 8'h00, pulse entry_error for one cycle, return to ENTRY with no sharp.
- Latency: '#' strobe in cycle N gives VALIDATE in N+1 and sharp high in N+2 (pass), or entry_error high in N+2 (fail).
- ADVANCE: sharp high one cycle, then ENTRY.
- complete_setting:
  - Checked in ENTRY only, and takes priority over a same-cycle key strobe (the key is dropped).
  - Rising level seen in ENTRY goes to LOAD. load_time pulses in the following cycle with *_bcd holding the entered values.
  - LOAD then goes to HOLD.
  - HOLD ignores all keys until complete_setting = 0, then returns to ENTRY. Fields are retained, not cleared.
- Keys arriving in VALIDATE, ADVANCE, LOAD or HOLD are dropped; no buffering.
- sharp, load_time and entry_error are never high in the same cycle.
- reset asserted in any state: next cycle is ENTRY, all fields 00, all pulses 0. A pending sharp or load is discarded.
- Unlisted key codes (4'hC-4'hF) are ignored in all states.

Test Plan:
- Hour entry: hour_en = 1; keys 1, 7, '#' → hour_bcd = 8'h17; sharp high exactly 1 cycle, 2 cycles after the '#' strobe; entry_error stays 0.
- Range reject: min_en = 1; keys 7, 5, '#' → entry_error 1-cycle pulse, min_bcd = 8'h00, no sharp; then keys 4, 5, '#' → min_bcd = 8'h45 and sharp pulse.
- Shift/clear: sec_en = 1; keys 1, 2, 3 → sec_bcd = 8'h23; '*' → 8'h00; keys 5, 9, '#' → 8'h59 and sharp.
- Commit: fields 08/30/15; raise complete_setting for 5 cycles → load_time exactly 1 cycle with 08/30/15; keys pressed during the hold are ignored; after release, digit keys are accepted again.
- Priority/idle: hour_en = min_en = 1, key 2 → only hour_bcd changes; all enables 0, keys 9 and '#' → no field change, no sharp.
- Reset mid-operation: '#' strobe, reset asserted in the next cycle → sharp never asserts; all *_bcd = 8'h00; subsequent digit entry works normally.
